// File: rtl/pipe_pkg.sv
// Shared MEM/WB pipeline types: default widths, the WB no-write encoding,
// the payload layout and the skid-register state encoding.
package pipe_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int WB_CTRL_WIDTH  = 2;

  localparam logic [WB_CTRL_WIDTH-1:0] WB_CTRL_NOP = '0;

  typedef struct packed {
    logic [WB_CTRL_WIDTH-1:0]  ctrl;
    logic [DATA_WIDTH-1:0]     read_data;
    logic [DATA_WIDTH-1:0]     result;
    logic [REG_ADDR_WIDTH-1:0] rd;
  } wb_payload_t;

  // Encoded as {skid_valid, main_valid}; ST_ILLEGAL is never reached.
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'b00,
    ST_ONE     = 2'b01,
    ST_ILLEGAL = 2'b10,
    ST_FULL    = 2'b11
  } skid_state_e;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline storage slot: payload register plus valid bit, with load
// enable and synchronous clear (clear wins). Capture edge chosen by NEG_EDGE.
module pipe_slot #(
  parameter int W        = 1,
  parameter bit NEG_EDGE = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic         valid_o,
  output logic [W-1:0] q_o
);

  logic         r_valid;
  logic [W-1:0] r_data;

  // Clearing only drops the valid bit; payload keeps its last value.
  generate
    if (NEG_EDGE) begin : g_neg
      always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_valid <= 1'b0;
          r_data  <= '0;
        end else if (clr_i) begin
          r_valid <= 1'b0;
        end else if (load_i) begin
          r_valid <= 1'b1;
          r_data  <= d_i;
        end
      end
    end else begin : g_pos
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_valid <= 1'b0;
          r_data  <= '0;
        end else if (clr_i) begin
          r_valid <= 1'b0;
        end else if (load_i) begin
          r_valid <= 1'b1;
          r_data  <= d_i;
        end
      end
    end
  endgenerate

  assign valid_o = r_valid;
  assign q_o     = r_data;

endmodule

// File: rtl/mem_wb_skid_reg.sv
// MEM/WB boundary register with a one-entry skid slot. Handshake: a transfer
// happens on a capture edge where valid & ready; ready never depends on valid.
module mem_wb_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W   = DATA_WIDTH,
  parameter int RADDR_W  = REG_ADDR_WIDTH,
  parameter int CTRL_W   = WB_CTRL_WIDTH,
  parameter bit NEG_EDGE = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [CTRL_W-1:0]  wb_ctrl_d,
  input  logic [DATA_W-1:0]  read_data_d,
  input  logic [DATA_W-1:0]  result_d,
  input  logic [RADDR_W-1:0] rd_d,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [CTRL_W-1:0]  wb_ctrl_q,
  output logic [DATA_W-1:0]  read_data_q,
  output logic [DATA_W-1:0]  result_q,
  output logic [RADDR_W-1:0] rd_q
);

  typedef struct packed {
    logic [CTRL_W-1:0]  ctrl;
    logic [DATA_W-1:0]  read_data;
    logic [DATA_W-1:0]  result;
    logic [RADDR_W-1:0] rd;
  } pay_t;

  localparam int PAY_W = $bits(pay_t);

  pay_t        w_in_pay;
  pay_t        w_main_pay;
  pay_t        w_skid_pay;
  pay_t        w_main_d;
  logic        w_main_valid;
  logic        w_skid_valid;
  logic        w_main_load;
  logic        w_main_clr;
  logic        w_skid_load;
  logic        w_skid_clr;
  logic        w_fire_in;
  logic        w_fire_out;
  skid_state_e w_state;

  assign w_in_pay   = {wb_ctrl_d, read_data_d, result_d, rd_d};
  assign w_fire_in  = in_valid_i & in_ready_o;
  assign w_fire_out = out_valid_o & out_ready_i;
  assign w_state    = skid_state_e'({w_skid_valid, w_main_valid});

  always_comb begin
    w_main_load = 1'b0;
    w_main_clr  = 1'b0;
    w_skid_load = 1'b0;
    w_skid_clr  = 1'b0;
    w_main_d    = w_in_pay;
    case (w_state)
      ST_EMPTY: w_main_load = w_fire_in;
      ST_ONE: begin
        if (w_fire_in && w_fire_out) begin
          w_main_load = 1'b1;
        end else if (w_fire_in) begin
          w_skid_load = 1'b1;
        end else if (w_fire_out) begin
          w_main_clr = 1'b1;
        end
      end
      ST_FULL: begin
        // Skid entry is the younger one; it moves up as main drains.
        if (w_fire_out) begin
          w_main_load = 1'b1;
          w_main_d    = w_skid_pay;
          w_skid_clr  = 1'b1;
        end
      end
      default: begin
        w_main_clr = 1'b1;
        w_skid_clr = 1'b1;
      end
    endcase
    if (flush_i) begin
      w_main_load = 1'b0;
      w_skid_load = 1'b0;
      w_main_clr  = 1'b1;
      w_skid_clr  = 1'b1;
    end
  end

  pipe_slot #(.W(PAY_W), .NEG_EDGE(NEG_EDGE)) u_main (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (w_main_clr),
    .load_i  (w_main_load),
    .d_i     (w_main_d),
    .valid_o (w_main_valid),
    .q_o     (w_main_pay)
  );

  pipe_slot #(.W(PAY_W), .NEG_EDGE(NEG_EDGE)) u_skid (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (w_skid_clr),
    .load_i  (w_skid_load),
    .d_i     (w_in_pay),
    .valid_o (w_skid_valid),
    .q_o     (w_skid_pay)
  );

  assign in_ready_o  = ~w_skid_valid;
  assign out_valid_o = w_main_valid;
  // Bubbles must never write the register file.
  assign wb_ctrl_q   = w_main_valid ? w_main_pay.ctrl : CTRL_W'(WB_CTRL_NOP);
  assign read_data_q = w_main_pay.read_data;
  assign result_q    = w_main_pay.result;
  assign rd_q        = w_main_pay.rd;

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Directed and randomised checks of mem_wb_skid_reg in both capture-edge modes.
module tb_mem_wb_skid_reg;
  import pipe_pkg::*;

  localparam int PW = $bits(wb_payload_t);

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  // Falling-edge instance
  logic        flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  ctrl_d, ctrl_q;
  logic [31:0] rdat_d, rdat_q, res_d, res_q;
  logic [4:0]  rd_d, rd_q;

  // Rising-edge instance
  logic        p_flush, p_in_valid, p_in_ready, p_out_valid, p_out_ready;
  logic [1:0]  p_ctrl_d, p_ctrl_q;
  logic [31:0] p_rdat_d, p_rdat_q, p_res_d, p_res_q;
  logic [4:0]  p_rd_d, p_rd_q;

  mem_wb_skid_reg #(.NEG_EDGE(1'b1)) u_dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .wb_ctrl_d(ctrl_d), .read_data_d(rdat_d), .result_d(res_d), .rd_d(rd_d),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .wb_ctrl_q(ctrl_q), .read_data_q(rdat_q), .result_q(res_q), .rd_q(rd_q)
  );

  mem_wb_skid_reg #(.NEG_EDGE(1'b0)) u_dut_pos (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(p_flush),
    .in_valid_i(p_in_valid), .in_ready_o(p_in_ready),
    .wb_ctrl_d(p_ctrl_d), .read_data_d(p_rdat_d), .result_d(p_res_d), .rd_d(p_rd_d),
    .out_valid_o(p_out_valid), .out_ready_i(p_out_ready),
    .wb_ctrl_q(p_ctrl_q), .read_data_q(p_rdat_q), .result_q(p_res_q), .rd_q(p_rd_q)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [PW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] c, input logic [31:0] rdat,
                       input logic [31:0] res, input logic [4:0] rd);
    in_valid = v; ctrl_d = c; rdat_d = rdat; res_d = res; rd_d = rd;
  endtask

  task automatic step_n();
    @(negedge clk); #1;
  endtask

  task automatic step_p();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [PW-1:0] pay;
    logic          fire_in, fire_out;

    flush = 1'b0; out_ready = 1'b1;
    drive(1'b1, 2'b10, 32'h0, 32'h0000_1234, 5'd5);
    p_flush = 1'b0; p_in_valid = 1'b0; p_out_ready = 1'b1;
    p_ctrl_d = '0; p_rdat_d = '0; p_res_d = '0; p_rd_d = '0;

    // Reset held across capture edges with valid input present
    step_n(); step_n();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready",  in_ready,  1'b1);
    chk("rst_wb_ctrl",   ctrl_q,    2'b00);
    chk("rst_read_data", rdat_q,    32'h0);
    chk("rst_result",    res_q,     32'h0);
    chk("rst_rd",        rd_q,      5'd0);
    chk("rst_pos_valid", p_out_valid, 1'b0);
    rst_ni = 1'b1;
    step_n();
    chk("first_valid",  out_valid, 1'b1);
    chk("first_ctrl",   ctrl_q,    2'b10);
    chk("first_result", res_q,     32'h0000_1234);
    chk("first_rd",     rd_q,      5'd5);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    step_n();
    chk("drain_valid",  out_valid, 1'b0);
    chk("bubble_ctrl",  ctrl_q,    2'b00);
    chk("hold_result",  res_q,     32'h0000_1234);

    // Streaming, falling-edge capture
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 2'b01, 32'(i) << 4, 32'(i), 5'(i));
      step_n();
      chk("stream_valid",  out_valid, 1'b1);
      chk("stream_result", res_q,     32'(i));
      chk("stream_rdat",   rdat_q,    32'(i) << 4);
      chk("stream_ready",  in_ready,  1'b1);
    end
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    step_n();
    chk("stream_end_valid", out_valid, 1'b0);

    // Back-pressure: one extra entry into skid, then orderly resume
    drive(1'b1, 2'b11, 32'h0, 32'h101, 5'd1);
    step_n();
    chk("bp_main", res_q, 32'h101);
    out_ready = 1'b0;
    drive(1'b1, 2'b11, 32'h0, 32'h102, 5'd2);
    step_n();
    chk("bp_hold",  res_q,    32'h101);
    chk("bp_ready", in_ready, 1'b0);
    drive(1'b1, 2'b11, 32'h0, 32'h103, 5'd3);
    step_n();
    chk("bp_stall1", res_q, 32'h101);
    step_n();
    chk("bp_stall2", res_q, 32'h101);
    chk("bp_stall_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    step_n();
    chk("bp_resume2", res_q,    32'h102);
    chk("bp_ready_up", in_ready, 1'b1);
    step_n();
    chk("bp_resume3", res_q, 32'h103);
    chk("bp_rd3",     rd_q,  5'd3);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    step_n();
    chk("bp_end_valid", out_valid, 1'b0);

    // Flush while FULL, with an incoming entry
    out_ready = 1'b0;
    drive(1'b1, 2'b10, 32'h0, 32'h104, 5'd4);
    step_n();
    drive(1'b1, 2'b10, 32'h0, 32'h105, 5'd5);
    step_n();
    chk("fl_full_ready", in_ready, 1'b0);
    flush = 1'b1;
    drive(1'b1, 2'b10, 32'h0, 32'h106, 5'd6);
    step_n();
    chk("fl_valid", out_valid, 1'b0);
    chk("fl_ctrl",  ctrl_q,    2'b00);
    chk("fl_ready", in_ready,  1'b1);
    flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    step_n();
    chk("fl_no_ghost", out_valid, 1'b0);

    // Streaming, rising-edge capture
    step_p();
    for (int i = 1; i <= 8; i++) begin
      p_in_valid = 1'b1; p_ctrl_d = 2'b01; p_rdat_d = 32'(i) << 4;
      p_res_d = 32'(i); p_rd_d = 5'(i);
      step_p();
      chk("pos_valid",  p_out_valid, 1'b1);
      chk("pos_result", p_res_q,     32'(i));
      chk("pos_ctrl",   p_ctrl_q,    2'b01);
      chk("pos_ready",  p_in_ready,  1'b1);
    end
    p_in_valid = 1'b0;
    step_p();
    chk("pos_end_valid", p_out_valid, 1'b0);
    chk("pos_bubble",    p_ctrl_q,    2'b00);

    // Random valid/ready/flush against a queue model (falling-edge instance)
    @(negedge clk); #1;
    for (int c = 0; c < 10000; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      pay = {2'($urandom_range(0, 3)), $urandom, $urandom, 5'($urandom_range(0, 31))};
      drive(($urandom_range(0, 3) != 0), pay[PW-1 -: 2], pay[68:37], pay[36:5], pay[4:0]);
      chk("rnd_valid", out_valid, exp_q.size() > 0);
      chk("rnd_ready", in_ready,  exp_q.size() < 2);
      if (exp_q.size() > 0)
        chk("rnd_payload", {ctrl_q, rdat_q, res_q, rd_q}, exp_q[0]);
      else
        chk("rnd_bubble", ctrl_q, 2'b00);
      fire_in  = in_valid && (exp_q.size() < 2);
      fire_out = (exp_q.size() > 0) && out_ready;
      step_n();
      if (fire_out) void'(exp_q.pop_front());
      if (flush) exp_q.delete();
      else if (fire_in) exp_q.push_back(pay);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
